// File: rtl/xeng_win_sched_if.sv
// Frame handshake, buffer read port and xeng_top stream of the window scheduler.
// master = scheduler side, slave = buffer / X-engine side.
interface xeng_win_sched_if #(
    parameter int ADDR_W     = 12,
    parameter int MCNT_WIDTH = 48
);
    logic                  frame_vld;
    logic [MCNT_WIDTH-1:0] frame_mcnt;
    logic                  frame_ack;
    logic                  frame_done;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_buf;
    logic                  xeng_sync;
    logic                  xeng_vld;
    logic [MCNT_WIDTH-1:0] xeng_mcnt;

    modport master (
        input  frame_vld, frame_mcnt,
        output frame_ack, frame_done, rd_en, rd_addr, rd_buf,
               xeng_sync, xeng_vld, xeng_mcnt
    );

    modport slave (
        output frame_vld, frame_mcnt,
        input  frame_ack, frame_done, rd_en, rd_addr, rd_buf,
               xeng_sync, xeng_vld, xeng_mcnt
    );
endinterface

// File: rtl/xeng_win_sched.sv
// X-engine window scheduler: accepts ping-pong frames, streams antenna-major read
// addresses and emits xeng sync/vld/mcnt aligned to the buffer read data.
module xeng_win_sched #(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int N_ANTS              = 32,
    parameter int BRAM_LATENCY        = 2,
    parameter int MCNT_WIDTH          = 48,
    parameter int UNDERRUN_CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arm,
    xeng_win_sched_if.master              bus,
    output logic                          busy,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt
);
    localparam int ANT_BITS = $clog2(N_ANTS);
    localparam int ADDR_W   = ANT_BITS + SERIAL_ACC_LEN_BITS;
    localparam int LAT      = BRAM_LATENCY;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                          state_reg, state_next;
    logic [ADDR_W-1:0]               addr_reg, addr_next;
    logic                            rd_buf_reg, rd_buf_next;
    logic                            started_reg, started_next;
    logic [MCNT_WIDTH-1:0]           mcnt_reg, mcnt_next;
    logic [UNDERRUN_CNT_WIDTH-1:0]   ucnt_reg, ucnt_next;
    logic [LAT-1:0]                  vld_pipe_reg, sync_pipe_reg, first_pipe_reg;
    logic [MCNT_WIDTH-1:0]           mcnt_hold_reg;

    logic                  rd_en, last_rd, first_rd, accept, start;
    logic [MCNT_WIDTH-1:0] xeng_mcnt_now;

    assign rd_en    = (state_reg == RUN);
    assign last_rd  = rd_en && (addr_reg == '1);
    assign first_rd = rd_en && (addr_reg == '0);

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        rd_buf_next  = rd_buf_reg;
        started_next = started_reg;
        mcnt_next    = mcnt_reg;
        ucnt_next    = ucnt_reg;
        accept       = 1'b0;
        start        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arm && bus.frame_vld) begin
                    accept     = 1'b1;
                    start      = 1'b1;
                    state_next = RUN;
                    addr_next  = '0;
                end
            end
            RUN: begin
                addr_next = addr_reg + ADDR_W'(1);
                if (last_rd) begin
                    if (arm && bus.frame_vld) begin
                        accept = 1'b1;
                    end else begin
                        // Stop or underrun: park the address on the last read
                        state_next = IDLE;
                        addr_next  = addr_reg;
                        if (arm && (ucnt_reg != '1)) begin
                            ucnt_next = ucnt_reg + UNDERRUN_CNT_WIDTH'(1);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // The very first frame after reset sits in half 0, so it does not toggle
        if (accept) begin
            mcnt_next    = bus.frame_mcnt;
            rd_buf_next  = rd_buf_reg ^ started_reg;
            started_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            rd_buf_reg     <= 1'b0;
            started_reg    <= 1'b0;
            mcnt_reg       <= '0;
            ucnt_reg       <= '0;
            vld_pipe_reg   <= '0;
            sync_pipe_reg  <= '0;
            first_pipe_reg <= '0;
            mcnt_hold_reg  <= '0;
        end else begin
            state_reg         <= state_next;
            addr_reg          <= addr_next;
            rd_buf_reg        <= rd_buf_next;
            started_reg       <= started_next;
            mcnt_reg          <= mcnt_next;
            ucnt_reg          <= ucnt_next;
            vld_pipe_reg[0]   <= rd_en;
            sync_pipe_reg[0]  <= start;
            first_pipe_reg[0] <= first_rd;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_reg[i]   <= vld_pipe_reg[i-1];
                sync_pipe_reg[i]  <= sync_pipe_reg[i-1];
                first_pipe_reg[i] <= first_pipe_reg[i-1];
            end
            mcnt_hold_reg <= xeng_mcnt_now;
        end
    end

    // mcnt_reg is stable for a whole window, so it is still the right frame's value
    // when that frame's first read emerges from the latency pipe.
    assign xeng_mcnt_now = first_pipe_reg[LAT-1] ? mcnt_reg : mcnt_hold_reg;

    assign bus.frame_ack  = accept && rst_n;
    assign bus.frame_done = last_rd;
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = addr_reg;
    assign bus.rd_buf     = rd_buf_reg;
    assign bus.xeng_sync  = sync_pipe_reg[LAT-1];
    assign bus.xeng_vld   = vld_pipe_reg[LAT-1];
    assign bus.xeng_mcnt  = xeng_mcnt_now;

    assign busy         = rd_en || (|vld_pipe_reg);
    assign underrun_cnt = ucnt_reg;
endmodule

// File: tb/tb_xeng_win_sched.sv
// Directed bench for xeng_win_sched: a window-level model checks every cycle,
// hand-computed expectations pin the key timing points.
module tb_xeng_win_sched;
    localparam int WIN  = 4096;
    localparam int LAT  = 2;
    localparam int RING = 16;
    localparam int UMAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        arm2 = 1'b0;
    logic        busy, busy2;
    logic [15:0] ucnt;
    logic [1:0]  ucnt2;

    xeng_win_sched_if #(.ADDR_W(12), .MCNT_WIDTH(48)) bus ();
    xeng_win_sched_if #(.ADDR_W(3),  .MCNT_WIDTH(48)) bus2 ();

    xeng_win_sched dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .bus(bus),
        .busy(busy), .underrun_cnt(ucnt)
    );

    xeng_win_sched #(
        .SERIAL_ACC_LEN_BITS(2), .N_ANTS(2), .BRAM_LATENCY(2),
        .MCNT_WIDTH(48), .UNDERRUN_CNT_WIDTH(2)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .arm(arm2), .bus(bus2),
        .busy(busy2), .underrun_cnt(ucnt2)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
            if (n_err >= 200) begin
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    endtask

    // ---------------- window-level reference model ----------------
    bit          m_act, m_started, m_rbuf;
    int          m_base, m_last, m_ucnt, m_off, m_slot, m_fut;
    bit          m_islast, m_accept;
    logic [47:0] m_mlat, m_xm;
    bit          m_vld_at [RING];
    bit          m_sync_at[RING];
    bit          m_upd_at [RING];
    logic [47:0] m_upd_val[RING];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_act = 0; m_started = 0; m_rbuf = 0; m_base = 0; m_last = 0;
            m_ucnt = 0; m_mlat = '0; m_xm = '0;
            for (int i = 0; i < RING; i++) begin
                m_vld_at[i] = 0; m_sync_at[i] = 0; m_upd_at[i] = 0; m_upd_val[i] = '0;
            end
        end
        m_slot   = cyc % RING;
        m_fut    = (cyc + LAT) % RING;
        m_off    = cyc - m_base;
        m_islast = m_act && (m_off == WIN - 1);
        m_accept = rst_n && arm && bus.frame_vld && (!m_act || m_islast);
        if (m_upd_at[m_slot]) m_xm = m_upd_val[m_slot];

        chk("rd_en",        64'(bus.rd_en),      64'(m_act));
        chk("rd_addr",      64'(bus.rd_addr),    64'(m_act ? m_off : m_last));
        chk("rd_buf",       64'(bus.rd_buf),     64'(m_rbuf));
        chk("frame_ack",    64'(bus.frame_ack),  64'(m_accept));
        chk("frame_done",   64'(bus.frame_done), 64'(m_islast));
        chk("xeng_sync",    64'(bus.xeng_sync),  64'(m_sync_at[m_slot]));
        chk("xeng_vld",     64'(bus.xeng_vld),   64'(m_vld_at[m_slot]));
        chk("xeng_mcnt",    64'(bus.xeng_mcnt),  64'(m_xm));
        chk("busy",         64'(busy),           64'(m_act || m_vld_at[m_slot]));
        chk("underrun_cnt", 64'(ucnt),           64'(m_ucnt));

        m_vld_at[m_slot] = 0; m_sync_at[m_slot] = 0; m_upd_at[m_slot] = 0;
        if (rst_n) begin
            if (m_act) begin
                m_vld_at[m_fut] = 1;
                if (m_off == 0) begin
                    m_upd_at[m_fut]  = 1;
                    m_upd_val[m_fut] = m_mlat;
                end
                m_last = m_off;
            end
            if (m_accept && !m_act) m_sync_at[m_fut] = 1;
            if (m_accept) begin
                m_mlat = bus.frame_mcnt;
                if (m_started) m_rbuf = !m_rbuf;
                m_started = 1;
                m_act     = 1;
                m_base    = cyc + 1;
            end else if (m_islast) begin
                m_act = 0;
                if (arm && m_ucnt < UMAX) m_ucnt++;
            end
        end
        cyc++;
    end

    int sync_n = 0;
    int vld_n = 0;
    always @(negedge clk) begin
        if (rst_n && bus.xeng_sync) sync_n++;
        if (rst_n && bus.xeng_vld)  vld_n++;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ticks(int n);
        repeat (n) tick();
    endtask
    task automatic mid();
        @(negedge clk);
    endtask

    int s0, v0;

    initial begin
        bus.frame_vld  = 1'b0; bus.frame_mcnt  = '0;
        bus2.frame_vld = 1'b0; bus2.frame_mcnt = '0;
        ticks(3); mid(); #1 rst_n = 1'b1;

        // 1: reset in the middle of a window
        tick(); arm = 1'b1; bus.frame_vld = 1'b1; bus.frame_mcnt = 48'd1; mid();
        chk("t1_ack", 64'(bus.frame_ack), 64'd1);
        tick(); bus.frame_vld = 1'b0;
        ticks(100);
        chk("t1_addr100", 64'(bus.rd_addr), 64'd100);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_rst_rd_en",  64'(bus.rd_en),     64'd0);
        chk("t1_rst_addr",   64'(bus.rd_addr),   64'd0);
        chk("t1_rst_vld",    64'(bus.xeng_vld),  64'd0);
        chk("t1_rst_mcnt",   64'(bus.xeng_mcnt), 64'd0);
        chk("t1_rst_busy",   64'(busy),          64'd0);
        chk("t1_rst_done",   64'(bus.frame_done),64'd0);
        ticks(3); mid(); #1 rst_n = 1'b1;
        tick(); mid();
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // 3: back-to-back frames 5,6,7
        s0 = sync_n; v0 = vld_n;
        tick(); bus.frame_vld = 1'b1; bus.frame_mcnt = 48'd5; mid();
        chk("t3_ack_a", 64'(bus.frame_ack), 64'd1);
        tick(); bus.frame_mcnt = 48'd6; mid();
        chk("t3_buf0", 64'(bus.rd_buf), 64'd0);
        chk("t3_addr0", 64'(bus.rd_addr), 64'd0);
        tick(); mid();
        chk("t3_sync", 64'(bus.xeng_sync), 64'd1);
        tick(); mid();
        chk("t3_vld_rise", 64'(bus.xeng_vld), 64'd1);
        chk("t3_mcnt5", 64'(bus.xeng_mcnt), 64'd5);
        ticks(4093); mid();
        chk("t3_done1", 64'(bus.frame_done), 64'd1);
        chk("t3_ack1", 64'(bus.frame_ack), 64'd1);
        chk("t3_addr_last", 64'(bus.rd_addr), 64'd4095);
        tick(); bus.frame_mcnt = 48'd7; mid();
        chk("t3_buf1", 64'(bus.rd_buf), 64'd1);
        chk("t3_addr_wrap", 64'(bus.rd_addr), 64'd0);
        tick(); mid();
        chk("t3_mcnt_hold5", 64'(bus.xeng_mcnt), 64'd5);
        tick(); mid();
        chk("t3_mcnt6", 64'(bus.xeng_mcnt), 64'd6);
        ticks(4093); mid();
        chk("t3_ack2", 64'(bus.frame_ack), 64'd1);
        tick(); arm = 1'b0; bus.frame_vld = 1'b0; mid();
        chk("t3_buf2", 64'(bus.rd_buf), 64'd0);
        ticks(2); mid();
        chk("t3_mcnt7", 64'(bus.xeng_mcnt), 64'd7);
        ticks(4093); mid();
        chk("t3_done3", 64'(bus.frame_done), 64'd1);
        chk("t3_noack3", 64'(bus.frame_ack), 64'd0);
        ticks(3); mid();
        chk("t3_vld_fall", 64'(bus.xeng_vld), 64'd0);
        chk("t3_busy_fall", 64'(busy), 64'd0);
        tick(); mid();
        chk("t3_one_sync", 64'(sync_n - s0), 64'd1);
        chk("t3_vld_cycles", 64'(vld_n - v0), 64'(3 * WIN));
        chk("t3_no_underrun", 64'(ucnt), 64'd0);

        // 4: underrun at the end of the 2nd frame
        s0 = sync_n;
        tick(); arm = 1'b1; bus.frame_vld = 1'b1; bus.frame_mcnt = 48'd10; mid();
        chk("t4_ack_a", 64'(bus.frame_ack), 64'd1);
        tick(); bus.frame_mcnt = 48'd11; mid();
        ticks(4095); mid();
        chk("t4_ack1", 64'(bus.frame_ack), 64'd1);
        tick(); bus.frame_vld = 1'b0; mid();
        ticks(4095); mid();
        chk("t4_done2", 64'(bus.frame_done), 64'd1);
        chk("t4_noack", 64'(bus.frame_ack), 64'd0);
        tick(); mid();
        chk("t4_ucnt1", 64'(ucnt), 64'd1);
        chk("t4_rd_en_off", 64'(bus.rd_en), 64'd0);
        chk("t4_addr_hold", 64'(bus.rd_addr), 64'd4095);
        tick(); mid();
        chk("t4_vld_l2", 64'(bus.xeng_vld), 64'd1);
        tick(); mid();
        chk("t4_vld_l3", 64'(bus.xeng_vld), 64'd0);
        chk("t4_busy_l3", 64'(busy), 64'd0);

        // 2 + 5: fresh accept after underrun, then arm dropped mid-window
        ticks(4); bus.frame_vld = 1'b1; bus.frame_mcnt = 48'd5; mid();
        chk("t2_ack", 64'(bus.frame_ack), 64'd1);
        tick(); bus.frame_vld = 1'b0; mid();
        chk("t2_rd_en", 64'(bus.rd_en), 64'd1);
        chk("t2_addr0", 64'(bus.rd_addr), 64'd0);
        tick(); mid();
        chk("t2_sync", 64'(bus.xeng_sync), 64'd1);
        tick(); mid();
        chk("t2_vld", 64'(bus.xeng_vld), 64'd1);
        chk("t2_mcnt5", 64'(bus.xeng_mcnt), 64'd5);
        ticks(7); arm = 1'b0; bus.frame_vld = 1'b1; bus.frame_mcnt = 48'd99; mid();
        chk("t5_noack_mid", 64'(bus.frame_ack), 64'd0);
        ticks(4086); mid();
        chk("t2_done", 64'(bus.frame_done), 64'd1);
        chk("t5_noack_l", 64'(bus.frame_ack), 64'd0);
        chk("t5_addr_last", 64'(bus.rd_addr), 64'd4095);
        tick(); mid();
        chk("t5_busy_l1", 64'(busy), 64'd1);
        tick(); mid();
        chk("t5_busy_l2", 64'(busy), 64'd1);
        tick(); mid();
        chk("t5_busy_l3", 64'(busy), 64'd0);
        chk("t5_vld_l3", 64'(bus.xeng_vld), 64'd0);
        chk("t5_ucnt_same", 64'(ucnt), 64'd1);
        ticks(5); mid();
        chk("t5_stays_idle", 64'(bus.rd_en), 64'd0);
        chk("t4_two_syncs", 64'(sync_n - s0), 64'd2);
        tick(); bus.frame_vld = 1'b0;

        // 6: saturating underrun counter on a small instance
        arm2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); bus2.frame_vld = 1'b1; bus2.frame_mcnt = 48'(i); mid();
            chk("t6_ack", 64'(bus2.frame_ack), 64'd1);
            tick(); bus2.frame_vld = 1'b0;
            ticks(11); mid();
            chk("t6_ucnt", 64'(ucnt2), 64'((i + 1 > 3) ? 3 : i + 1));
            chk("t6_busy", 64'(busy2), 64'd0);
        end
        arm2 = 1'b0;

        tick(); mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
